somador_serial_nbits: RTL

SOMADOR_SERIAL_NBITS -- requirements
Module: somador_serial_nbits

---
 rtl/somador_serial_nbits.sv | 130 +++++++++++++
 1 files changed

// File: rtl/somador_serial_nbits.sv
// Bit-serial N-bit adder/subtractor.
// A single 1-bit full-adder slice processes one operand bit per clock, LSB
// first. Subtraction is done as A + ~B + ~Cin. The result appears N cycles
// after the start request and is held until the next completion.
//
// state  | meaning
// OCIOSO | idle, outputs hold the last result, waiting for inicio
// CALC   | one bit per cycle through the slice, N cycles
// FIM    | result valid (pronto=1); inicio here chains the next operation
module somador_serial_nbits #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inicio,
  input  logic         op,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic [N-1:0] S,
  output logic         Cout,
  output logic         V,
  output logic         ocupado,
  output logic         pronto
);

  localparam int CNT_W = $clog2(N) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    CALC   = 2'd1,
    FIM    = 2'd2
  } state_t;

  state_t state, next_state;

  logic [N-1:0]     a_reg;
  logic [N-1:0]     b_reg;   // already inverted for subtraction
  logic [N-1:0]     shift_reg;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic start;
  logic done;

  logic a_bit, b_bit, sum_bit, carry_out;

  // The slice: operands are shifted right each cycle, so bit 0 is always current.
  always_comb begin
    a_bit     = a_reg[0];
    b_bit     = b_reg[0];
    sum_bit   = a_bit ^ b_bit ^ carry;
    carry_out = (a_bit & b_bit) | (carry & (a_bit ^ b_bit));
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) state <= OCIOSO;
    else     state <= next_state;
  end

  // Next-state logic and status outputs.
  always_comb begin
    next_state = state;
    start      = 1'b0;
    done       = 1'b0;
    ocupado    = 1'b0;
    pronto     = 1'b0;
    case (state)
      OCIOSO: begin
        if (inicio) begin
          next_state = CALC;
          start      = 1'b1;
        end else begin
          next_state = OCIOSO;
        end
      end
      CALC: begin
        ocupado = 1'b1;
        if (cnt == LAST) begin
          done       = 1'b1;
          next_state = FIM;
        end
      end
      FIM: begin
        pronto = 1'b1;
        if (inicio) begin
          next_state = CALC;
          start      = 1'b1;
        end else begin
          next_state = OCIOSO;
        end
      end
      default: next_state = OCIOSO;
    endcase
  end

  // Datapath: operand latch, serial accumulation and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      shift_reg <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      S         <= '0;
      Cout      <= 1'b0;
      V         <= 1'b0;
    end else if (start) begin
      a_reg <= A;
      b_reg <= op ? ~B : B;
      carry <= op ? ~Cin : Cin;
      cnt   <= '0;
    end else if (state == CALC) begin
      a_reg     <= a_reg >> 1;
      b_reg     <= b_reg >> 1;
      carry     <= carry_out;
      shift_reg <= {sum_bit, shift_reg[N-1:1]};
      cnt       <= cnt + CNT_W'(1);
      if (done) begin
        S    <= {sum_bit, shift_reg[N-1:1]};
        Cout <= carry_out;
        // carry holds the carry into the MSB during the last slice cycle
        V    <= carry ^ carry_out;
      end
    end
  end

endmodule
